// File: rtl/axil_cfg_seq.sv
// Configuration write sequencer: plays a table of write/wait commands out to the
// cfg port of the AXI-lite write master, one handshaked write per write entry.
`timescale 1ns/1ps
module axil_cfg_seq #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          s_axi_aclk,
    input  logic          s_axi_aresetn,
    input  logic          tbl_we,
    input  logic [AW-1:0] tbl_addr,
    input  logic          tbl_op,
    input  logic [31:0]   tbl_waddr,
    input  logic [31:0]   tbl_wdata,
    input  logic          seq_start,
    input  logic [AW:0]   seq_len,
    input  logic          seq_abort,
    output logic          seq_busy,
    output logic          seq_done,
    output logic          seq_aborted,
    output logic [AW:0]   seq_idx,
    output logic          s_axi_cfg_wvalid,
    output logic [31:0]   s_axi_cfg_waddr,
    output logic [31:0]   s_axi_cfg_wdata,
    input  logic          s_axi_cfg_wready
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [2:0]  state;
    logic [AW:0] len_q;
    logic [31:0] cnt;
    logic        abort_pend;
    logic [64:0] mem [DEPTH];
    logic [64:0] rd_q;

    logic        rd_op;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic [AW:0] len_clamp;
    logic [AW:0] idx_next;
    logic        abort_now;
    logic        adv_done;

    assign rd_op     = rd_q[64];
    assign rd_addr   = rd_q[63:32];
    assign rd_data   = rd_q[31:0];
    assign len_clamp = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
    assign idx_next  = seq_idx + (AW+1)'(1);
    assign abort_now = abort_pend | seq_abort;
    assign adv_done  = (idx_next == len_q) || abort_now;
    assign seq_done  = (state == S_DONE);

    // Table RAM: not reset, writes locked out while a sequence is running.
    always_ff @(posedge s_axi_aclk) begin
        if (tbl_we && !seq_busy) begin
            mem[tbl_addr] <= {tbl_op, tbl_waddr, tbl_wdata};
        end
        if (state == S_FETCH) begin
            rd_q <= mem[seq_idx[AW-1:0]];
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state            <= S_IDLE;
            len_q            <= '0;
            cnt              <= '0;
            abort_pend       <= 1'b0;
            seq_busy         <= 1'b0;
            seq_aborted      <= 1'b0;
            seq_idx          <= '0;
            s_axi_cfg_wvalid <= 1'b0;
            s_axi_cfg_waddr  <= '0;
            s_axi_cfg_wdata  <= '0;
        end else begin
            if (seq_abort && seq_busy) begin
                abort_pend <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (seq_start) begin
                        len_q       <= len_clamp;
                        seq_idx     <= '0;
                        seq_aborted <= 1'b0;
                        abort_pend  <= 1'b0;
                        seq_busy    <= 1'b1;
                        state       <= (len_clamp == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (abort_now) begin
                        seq_aborted <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (abort_now) begin
                        seq_aborted <= 1'b1;
                        state       <= S_DONE;
                    end else if (!rd_op) begin
                        s_axi_cfg_waddr  <= rd_addr;
                        s_axi_cfg_wdata  <= rd_data;
                        s_axi_cfg_wvalid <= 1'b1;
                        state            <= S_ISSUE;
                    end else if (rd_data != '0) begin
                        cnt   <= rd_data;
                        state <= S_WAIT;
                    end else begin
                        seq_idx     <= idx_next;
                        seq_aborted <= abort_now;
                        state       <= adv_done ? S_DONE : S_FETCH;
                    end
                end
                // An accepted-but-unfinished request is never withdrawn; abort waits here.
                S_ISSUE: begin
                    if (s_axi_cfg_wready) begin
                        s_axi_cfg_wvalid <= 1'b0;
                        seq_idx          <= idx_next;
                        seq_aborted      <= abort_now;
                        state            <= adv_done ? S_DONE : S_FETCH;
                    end
                end
                S_WAIT: begin
                    if (abort_now) begin
                        seq_aborted <= 1'b1;
                        state       <= S_DONE;
                    end else if (cnt == 32'd1) begin
                        seq_idx     <= idx_next;
                        seq_aborted <= abort_now;
                        state       <= adv_done ? S_DONE : S_FETCH;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                S_DONE: begin
                    seq_busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cfg_seq.sv
// Directed bench for axil_cfg_seq: table model plus a write scoreboard checked
// at every cfg handshake, with timing taken from a free-running edge counter.
`timescale 1ns/1ps
module tb_axil_cfg_seq;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk;
    logic          rst_n;
    logic          tbl_we;
    logic [AW-1:0] tbl_addr;
    logic          tbl_op;
    logic [31:0]   tbl_waddr;
    logic [31:0]   tbl_wdata;
    logic          seq_start;
    logic [AW:0]   seq_len;
    logic          seq_abort;
    logic          seq_busy;
    logic          seq_done;
    logic          seq_aborted;
    logic [AW:0]   seq_idx;
    logic          wvalid;
    logic [31:0]   waddr;
    logic [31:0]   wdata;
    logic          wready;

    axil_cfg_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
        .s_axi_aclk       (clk),
        .s_axi_aresetn    (rst_n),
        .tbl_we           (tbl_we),
        .tbl_addr         (tbl_addr),
        .tbl_op           (tbl_op),
        .tbl_waddr        (tbl_waddr),
        .tbl_wdata        (tbl_wdata),
        .seq_start        (seq_start),
        .seq_len          (seq_len),
        .seq_abort        (seq_abort),
        .seq_busy         (seq_busy),
        .seq_done         (seq_done),
        .seq_aborted      (seq_aborted),
        .seq_idx          (seq_idx),
        .s_axi_cfg_wvalid (wvalid),
        .s_axi_cfg_waddr  (waddr),
        .s_axi_cfg_wdata  (wdata),
        .s_axi_cfg_wready (wready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int ready_delay = 0;
    int rwait = 0;
    int xfer_count = 0;
    int done_count = 0;
    int done_cyc = 0;
    int rise_q[$];
    int hs_q[$];
    logic [63:0] sb[$];

    logic        m_op   [DEPTH];
    logic [31:0] m_addr [DEPTH];
    logic [31:0] m_data [DEPTH];

    logic        prev_wv = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_aw = '0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Ready model: wready low for ready_delay cycles of each request, then high.
    always @(posedge clk) begin
        #1;
        if (!wvalid) begin
            rwait  = 0;
            wready = (ready_delay == 0);
        end else if (rwait >= ready_delay) begin
            wready = 1'b1;
        end else begin
            rwait++;
            wready = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wv    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_wvalid", {63'd0, wvalid}, 64'd1);
                checkOutput("stall_addr_data", {waddr, wdata}, prev_aw);
            end
            if (wvalid && !prev_wv) rise_q.push_back(cyc);
            if (wvalid && wready) begin
                hs_q.push_back(cyc + 1);
                xfer_count++;
                checkOutput("unexpected_xfer", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) checkOutput("xfer_addr_data", {waddr, wdata}, sb.pop_front());
            end
            if (seq_done) begin
                done_count++;
                done_cyc = cyc;
            end
            prev_wv    = wvalid;
            prev_stall = wvalid && !wready;
            prev_aw    = {waddr, wdata};
        end
    end

    task automatic loadEntry(input int idx, input logic op, input logic [31:0] a, input logic [31:0] d);
        tbl_we    = 1'b1;
        tbl_addr  = AW'(idx);
        tbl_op    = op;
        tbl_waddr = a;
        tbl_wdata = d;
        m_op[idx]   = op;
        m_addr[idx] = a;
        m_data[idx] = d;
        waitEdge();
        tbl_we = 1'b0;
    endtask

    // Starts a run and queues the first max_writes write entries it should play.
    task automatic applyStimulus(input int len, input int max_writes);
        int eff;
        int pushed;
        eff    = (len > DEPTH) ? DEPTH : len;
        pushed = 0;
        for (int i = 0; i < eff; i++) begin
            if (!m_op[i] && pushed < max_writes) begin
                sb.push_back({m_addr[i], m_data[i]});
                pushed++;
            end
        end
        rise_q.delete();
        hs_q.delete();
        seq_start = 1'b1;
        seq_len   = (AW+1)'(len);
        t0        = cyc;
        waitEdge();
        seq_start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int d0;
        d0 = done_count;
        for (int i = 0; i < budget; i++) begin
            if (done_count != d0) break;
            waitEdge();
        end
        repeat (3) waitEdge();
        checkOutput("done_pulses", 64'(done_count - d0), 64'd1);
    endtask

    task automatic waitWvalid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (wvalid) break;
            waitEdge();
        end
        checkOutput("wvalid_rise", {63'd0, wvalid}, 64'd1);
    endtask

    initial begin
        int x0;
        int gap;
        int c;
        rst_n = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_op = 1'b0;
        tbl_waddr = '0; tbl_wdata = '0; seq_start = 1'b0; seq_len = '0;
        seq_abort = 1'b0; wready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            m_op[i] = 1'b1; m_addr[i] = '0; m_data[i] = '0;
        end
        repeat (3) waitEdge();
        checkOutput("rst_wvalid", {63'd0, wvalid}, 64'd0);
        checkOutput("rst_busy", {63'd0, seq_busy}, 64'd0);
        checkOutput("rst_done", {63'd0, seq_done}, 64'd0);
        checkOutput("rst_aborted", {63'd0, seq_aborted}, 64'd0);
        checkOutput("rst_idx", 64'(seq_idx), 64'd0);
        rst_n = 1'b1;
        waitEdge();

        $display("[TB] three back-to-back writes");
        loadEntry(0, 1'b0, 32'h10, 32'hA);
        loadEntry(1, 1'b0, 32'h14, 32'hB);
        loadEntry(2, 1'b0, 32'h18, 32'hC);
        x0 = xfer_count;
        applyStimulus(3, 3);
        waitDone(100);
        checkOutput("t1_xfers", 64'(xfer_count - x0), 64'd3);
        checkOutput("t1_rises", 64'(rise_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < rise_q.size()) checkOutput("t1_rise_edge", 64'(rise_q[i] - t0), 64'(3 * i + 3));
        end
        checkOutput("t1_done_edge", 64'(done_cyc - t0), 64'd10);
        checkOutput("t1_idx", 64'(seq_idx), 64'd3);
        checkOutput("t1_busy", {63'd0, seq_busy}, 64'd0);
        checkOutput("t1_aborted", {63'd0, seq_aborted}, 64'd0);

        $display("[TB] slow ready, table write and start while busy");
        ready_delay = 5;
        x0 = xfer_count;
        applyStimulus(3, 3);
        tbl_we = 1'b1; tbl_addr = 2; tbl_op = 1'b0;
        tbl_waddr = 32'hDEAD; tbl_wdata = 32'hBEEF;
        seq_start = 1'b1; seq_len = 1;
        waitEdge();
        tbl_we = 1'b0; seq_start = 1'b0;
        waitDone(200);
        checkOutput("t2_xfers", 64'(xfer_count - x0), 64'd3);
        checkOutput("t2_sb_empty", 64'(sb.size()), 64'd0);
        checkOutput("t2_idx", 64'(seq_idx), 64'd3);

        $display("[TB] write, wait(10), write");
        ready_delay = 0;
        loadEntry(0, 1'b0, 32'h20, 32'h1);
        loadEntry(1, 1'b1, 32'h0, 32'd10);
        loadEntry(2, 1'b0, 32'h24, 32'h2);
        x0 = xfer_count;
        applyStimulus(3, 2);
        waitDone(200);
        checkOutput("t3_xfers", 64'(xfer_count - x0), 64'd2);
        if (hs_q.size() >= 1 && rise_q.size() >= 2) begin
            gap = rise_q[1] - hs_q[0];
            checkOutput("t3_gap_min", {63'd0, gap >= 13}, 64'd1);
            // FETCH + DECODE of the wait entry, 10 WAIT cycles, FETCH + DECODE of the write
            checkOutput("t3_gap", 64'(gap), 64'd14);
        end

        $display("[TB] write, wait(0), write");
        loadEntry(1, 1'b1, 32'h0, 32'd0);
        x0 = xfer_count;
        applyStimulus(3, 2);
        waitDone(100);
        checkOutput("t3b_xfers", 64'(xfer_count - x0), 64'd2);
        if (hs_q.size() >= 1 && rise_q.size() >= 2) begin
            checkOutput("t3b_gap", 64'(rise_q[1] - hs_q[0]), 64'd4);
        end

        $display("[TB] zero length and over-length runs");
        x0 = xfer_count;
        applyStimulus(0, 0);
        waitDone(20);
        checkOutput("t4_len0_xfers", 64'(xfer_count - x0), 64'd0);
        checkOutput("t4_len0_done_edge", 64'(done_cyc - t0), 64'd1);
        checkOutput("t4_len0_idx", 64'(seq_idx), 64'd0);
        for (int i = 0; i < DEPTH; i++) loadEntry(i, 1'b0, 32'h1000 + 32'(4 * i), 32'(i));
        x0 = xfer_count;
        applyStimulus(DEPTH + 1, DEPTH);
        waitDone(400);
        checkOutput("t4_clamp_xfers", 64'(xfer_count - x0), 64'(DEPTH));
        checkOutput("t4_clamp_idx", 64'(seq_idx), 64'(DEPTH));
        checkOutput("t4_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] abort while a write is stalled");
        loadEntry(0, 1'b0, 32'h10, 32'hA);
        loadEntry(1, 1'b0, 32'h14, 32'hB);
        loadEntry(2, 1'b0, 32'h18, 32'hC);
        ready_delay = 1000;
        x0 = xfer_count;
        applyStimulus(3, 1);
        waitWvalid(20);
        seq_abort = 1'b1;
        waitEdge();
        seq_abort = 1'b0;
        repeat (4) waitEdge();
        checkOutput("t5_wvalid_held", {63'd0, wvalid}, 64'd1);
        ready_delay = 0;
        waitDone(50);
        repeat (10) waitEdge();
        checkOutput("t5_xfers", 64'(xfer_count - x0), 64'd1);
        checkOutput("t5_aborted", {63'd0, seq_aborted}, 64'd1);
        checkOutput("t5_idx", 64'(seq_idx), 64'd1);
        checkOutput("t5_wvalid_low", {63'd0, wvalid}, 64'd0);

        $display("[TB] abort during a wait entry");
        loadEntry(0, 1'b0, 32'h20, 32'h1);
        loadEntry(1, 1'b1, 32'h0, 32'd10);
        loadEntry(2, 1'b0, 32'h24, 32'h2);
        x0 = xfer_count;
        applyStimulus(3, 1);
        repeat (2) waitEdge();
        checkOutput("t5b_aborted_cleared", {63'd0, seq_aborted}, 64'd0);
        for (int i = 0; i < 30; i++) begin
            if (xfer_count != x0) break;
            waitEdge();
        end
        if (hs_q.size() >= 1) begin
            for (int i = 0; i < 30; i++) begin
                if (cyc >= hs_q[0] + 5) break;
                waitEdge();
            end
        end
        seq_abort = 1'b1;
        c = cyc;
        waitEdge();
        seq_abort = 1'b0;
        waitDone(20);
        checkOutput("t5b_done_edge", 64'(done_cyc - c), 64'd1);
        checkOutput("t5b_aborted", {63'd0, seq_aborted}, 64'd1);
        checkOutput("t5b_xfers", 64'(xfer_count - x0), 64'd1);
        checkOutput("t5b_idx", 64'(seq_idx), 64'd1);

        $display("[TB] reset mid-issue");
        ready_delay = 1000;
        x0 = xfer_count;
        applyStimulus(3, 0);
        waitWvalid(20);
        tbl_we = 1'b1; tbl_addr = 0; tbl_op = 1'b0;
        tbl_waddr = 32'hDEAD; tbl_wdata = 32'hBEEF;
        waitEdge();
        tbl_we = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_wvalid", {63'd0, wvalid}, 64'd0);
        checkOutput("t6_rst_busy", {63'd0, seq_busy}, 64'd0);
        checkOutput("t6_rst_idx", 64'(seq_idx), 64'd0);
        repeat (2) waitEdge();
        rst_n = 1'b1;
        ready_delay = 0;
        waitEdge();
        applyStimulus(1, 1);
        waitDone(30);
        checkOutput("t6_xfers", 64'(xfer_count - x0), 64'd1);
        checkOutput("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
